lcd_line_buffer: RTL and testbench
==================================

# lcd_line_buffer

Ping-pong line buffer between the pixel source and the LCD frame timing engine. A writer fills one bank with a full line of 32-bit pixel words while the timing engine drains the other bank one word per clock during the data portion of each line. The block tracks the line index within the frame, flags underrun when the engine asks for data that is not ready, and can be flushed at frame boundaries.

## Interface
- WORDS_PER_LINE, 40, data words per LCD line (valid-high clocks per line)
- LINES_PER_FRAME, 1280, lines per frame
- DATA_WIDTH, 32, pixel word width
- i_clock  in  1  block clock (PLL output shared with the LCD timing engine); all logic on rising edge
- i_nreset  in  1  reset, asynchronous, active-low
- i_wrData  in  DATA_WIDTH  pixel word from source
- i_wrValid  in  1  i_wrData valid; word accepted when i_wrValid & o_wrReady
- o_wrReady  out  1  current write bank not full
- i_rdEnable  in  1  timing engine consumes one word this cycle
- o_rdData  out  DATA_WIDTH  registered read data
- o_lineReady  out  1  current read bank holds a complete line
- o_rdLine  out  11  index of line currently being read, 0..LINES_PER_FRAME-1
- o_frameDone  out  1  one-cycle pulse when last line of frame is released
- o_underrun  out  1  sticky: read requested with no complete line
- i_flush  in  1  synchronous clear of both banks and all counters

## Operation
- Storage: 2 banks x WORDS_PER_LINE x DATA_WIDTH; per-bank full flag; write bank select wb, read bank select rb, write pointer wp, read pointer rp (6 bits each, 0..WORDS_PER_LINE-1).
- o_wrReady = ~full[wb]; o_lineReady = full[rb] (combinational from registered flags).
- Write: on accepted word, store at bank[wb][wp], wp+1. When wp == WORDS_PER_LINE-1 and word accepted: full[wb] <= 1, wp <= 0, wb toggles.
- Read, full[rb]=1 and i_rdEnable: o_rdData <= bank[rb][rp], rp+1. When rp == WORDS_PER_LINE-1: full[rb] <= 0, rp <= 0, rb toggles, o_rdLine increments; if o_rdLine == LINES_PER_FRAME-1, o_rdLine <= 0 and o_frameDone pulses.
- Read, full[rb]=0 and i_rdEnable (underrun): o_rdData <= 0, o_underrun <= 1, rp/rb/o_rdLine unchanged.
- i_rdEnable low: o_rdData holds.
- Simultaneous write completing bank A and read releasing bank B in same cycle: both take effect; neither flag update blocks the other.
- Bank cannot be both written and read: writer only writes a non-full bank, reader only reads a full bank.
- i_flush: full flags, wb, rb, wp, rp, o_rdLine, o_rdData, o_frameDone, o_underrun all cleared; dominates any same-cycle write/read (data that cycle discarded, not accepted).
- o_underrun cleared only by reset or i_flush.

## Timing
- Reset (i_nreset low, async): o_rdData 0, o_rdLine 0, o_frameDone 0, o_underrun 0, o_lineReady 0, o_wrReady 1; all pointers/selects 0.
- Read latency: 1 cycle; word k of a line appears on o_rdData the cycle after the k-th i_rdEnable. Timing engine drives i_rdEnable one cycle ahead of its valid strobe.
- Write-to-read: o_lineReady rises the cycle after the 40th word of a line is accepted.
- o_wrReady falls the cycle after the accepted 40th word only if the other bank is still full; otherwise stays high (writer continues into other bank with no bubble).
- Throughput: one write and one read per cycle sustained.
- o_frameDone high exactly one cycle, coincident with o_rdData carrying the last word of line 1279.

## Test plan
- Reset then 40 writes of 0x1000+k -> o_lineReady=1 one cycle after 40th; 40 consecutive i_rdEnable -> o_rdData 0x1000..0x1027 in order, 1-cycle latency, o_rdLine 0->1, o_lineReady=0.
- Write 80 words with reader idle -> o_wrReady=0 after 80th; 81st word held off; read 40 -> o_wrReady returns 1, bank 2 data 0x1028.. then readable.
- i_rdEnable with no complete line -> o_rdData=0, o_underrun=1 and stays 1; o_rdLine unchanged; i_flush clears it.
- Streaming 1280 lines with concurrent write/read each cycle -> no underrun, o_frameDone one-cycle pulse on last word of line 1279, o_rdLine wraps to 0.
- i_flush asserted mid-line (rp=17, one bank full) with i_wrValid high -> all flags/pointers 0, word not stored, o_wrReady=1, o_lineReady=0 next cycle.
- i_nreset asserted asynchronously mid-read -> outputs reach reset values without a clock edge; normal operation after release.

Source files
------------

// File: rtl/lcd_line_buffer_if.sv
// Write/read channels between pixel source, timing engine and line buffer.
// master drives the i_* side, slave is the line buffer itself.
interface lcd_line_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_wrData;
    logic                  i_wrValid;
    logic                  o_wrReady;
    logic                  i_rdEnable;
    logic [DATA_WIDTH-1:0] o_rdData;
    logic                  o_lineReady;
    logic [10:0]           o_rdLine;
    logic                  o_frameDone;
    logic                  o_underrun;
    logic                  i_flush;

    modport master (
        output i_wrData,
        output i_wrValid,
        output i_rdEnable,
        output i_flush,
        input  o_wrReady,
        input  o_rdData,
        input  o_lineReady,
        input  o_rdLine,
        input  o_frameDone,
        input  o_underrun
    );

    modport slave (
        input  i_wrData,
        input  i_wrValid,
        input  i_rdEnable,
        input  i_flush,
        output o_wrReady,
        output o_rdData,
        output o_lineReady,
        output o_rdLine,
        output o_frameDone,
        output o_underrun
    );
endinterface

// File: rtl/lcd_line_buffer.sv
// Ping-pong line buffer: source fills one bank while the LCD timing
// engine drains the other, tracking line index, frame end and underrun.
module lcd_line_buffer #(
    parameter int WORDS_PER_LINE  = 40,
    parameter int LINES_PER_FRAME = 1280,
    parameter int DATA_WIDTH      = 32
) (
    input  logic             i_clock,
    input  logic             i_nreset,
    lcd_line_buffer_if.slave bus
);
    localparam int PW = $clog2(WORDS_PER_LINE);
    localparam int LW = 11;

    logic [DATA_WIDTH-1:0] r_bank [2][WORDS_PER_LINE];
    logic [1:0]            r_full;
    logic                  r_wb;
    logic                  r_rb;
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [LW-1:0]         r_rdLine;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_frameDone;
    logic                  r_underrun;

    logic                  w_wrFire;
    logic                  w_rdFire;
    logic                  w_wrLast;
    logic                  w_rdLast;
    logic                  w_frameLast;
    logic [1:0]            w_fullSet;
    logic [1:0]            w_fullClr;

    assign w_wrFire    = bus.i_wrValid & ~r_full[r_wb] & ~bus.i_flush;
    assign w_rdFire    = bus.i_rdEnable & r_full[r_rb] & ~bus.i_flush;
    assign w_wrLast    = (r_wp == PW'(WORDS_PER_LINE - 1));
    assign w_rdLast    = (r_rp == PW'(WORDS_PER_LINE - 1));
    assign w_frameLast = (r_rdLine == LW'(LINES_PER_FRAME - 1));

    // Writer and reader never own the same bank, so set and clear are disjoint.
    assign w_fullSet = {2{w_wrFire & w_wrLast}} & (r_wb ? 2'b10 : 2'b01);
    assign w_fullClr = {2{w_rdFire & w_rdLast}} & (r_rb ? 2'b10 : 2'b01);

    always_ff @(posedge i_clock) begin
        if (w_wrFire) begin
            r_bank[r_wb][r_wp] <= bus.i_wrData;
        end
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_full      <= '0;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_rdLine    <= '0;
            r_rdData    <= '0;
            r_frameDone <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (bus.i_flush) begin
            r_full      <= '0;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_rdLine    <= '0;
            r_rdData    <= '0;
            r_frameDone <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_full      <= (r_full | w_fullSet) & ~w_fullClr;
            r_frameDone <= 1'b0;
            if (w_wrFire) begin
                if (w_wrLast) begin
                    r_wp <= '0;
                    r_wb <= ~r_wb;
                end else begin
                    r_wp <= r_wp + 1'b1;
                end
            end
            if (w_rdFire) begin
                r_rdData <= r_bank[r_rb][r_rp];
                if (w_rdLast) begin
                    r_rp <= '0;
                    r_rb <= ~r_rb;
                    if (w_frameLast) begin
                        r_rdLine    <= '0;
                        r_frameDone <= 1'b1;
                    end else begin
                        r_rdLine <= r_rdLine + 1'b1;
                    end
                end else begin
                    r_rp <= r_rp + 1'b1;
                end
            end else if (bus.i_rdEnable) begin
                r_rdData   <= '0;
                r_underrun <= 1'b1;
            end
        end
    end

    assign bus.o_wrReady   = ~r_full[r_wb];
    assign bus.o_lineReady = r_full[r_rb];
    assign bus.o_rdData    = r_rdData;
    assign bus.o_rdLine    = r_rdLine;
    assign bus.o_frameDone = r_frameDone;
    assign bus.o_underrun  = r_underrun;
endmodule

// File: tb/tb_lcd_line_buffer.sv
// Scoreboard bench for lcd_line_buffer: directed vectors push expected
// read words; a negedge monitor pops and compares every read result.
module tb_lcd_line_buffer;
    localparam int WPL = 40;
    localparam int NLN = 1280;
    localparam int NW  = WPL * NLN;

    typedef struct {
        logic [31:0] d;
        logic        fd;
    } exp_t;

    logic clk;
    logic nreset;
    int   n_run;
    int   n_fail;
    exp_t q[$];
    exp_t e;
    logic pend;

    lcd_line_buffer_if #(.DATA_WIDTH(32)) bus ();

    lcd_line_buffer #(
        .WORDS_PER_LINE (WPL),
        .LINES_PER_FRAME(NLN),
        .DATA_WIDTH     (32)
    ) dut (
        .i_clock (clk),
        .i_nreset(nreset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) pend <= 1'b0;
        else         pend <= bus.i_rdEnable & ~bus.i_flush;
    end

    always @(negedge clk) begin
        if (pend) begin
            n_run++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: read result %h with nothing expected", bus.o_rdData);
            end else begin
                e = q.pop_front();
                if (bus.o_rdData !== e.d) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", bus.o_rdData, e.d);
                end
                n_run++;
                if (bus.o_frameDone !== e.fd) begin
                    n_fail++;
                    $display("FAIL frame_done: got %b expected %b", bus.o_frameDone, e.fd);
                end
            end
        end else begin
            n_run++;
            if (bus.o_frameDone !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_done_idle: got %b expected 0", bus.o_frameDone);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        bus.i_wrValid = 1'b1;
        bus.i_wrData  = d;
        step();
        bus.i_wrValid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] d, input logic fd);
        bus.i_rdEnable = 1'b1;
        q.push_back('{d, fd});
        step();
        bus.i_rdEnable = 1'b0;
    endtask

    initial begin
        int nw;
        int nr;
        int cyc;
        logic wr_ok;

        n_run          = 0;
        n_fail         = 0;
        nreset         = 1'b0;
        bus.i_wrData   = '0;
        bus.i_wrValid  = 1'b0;
        bus.i_rdEnable = 1'b0;
        bus.i_flush    = 1'b0;
        repeat (3) step();
        nreset = 1'b1;
        step();

        chk("rst_rdData", bus.o_rdData, 32'h0);
        chk("rst_rdLine", 32'(bus.o_rdLine), 32'h0);
        chk("rst_underrun", 32'(bus.o_underrun), 32'h0);
        chk("rst_lineReady", 32'(bus.o_lineReady), 32'h0);
        chk("rst_wrReady", 32'(bus.o_wrReady), 32'h1);

        // One line in, one line out
        for (int k = 0; k < WPL - 1; k++) wr(32'h1000 + 32'(k));
        chk("lr_before_40th", 32'(bus.o_lineReady), 32'h0);
        wr(32'h1000 + 32'(WPL - 1));
        chk("lr_after_40th", 32'(bus.o_lineReady), 32'h1);
        chk("wrReady_bank_free", 32'(bus.o_wrReady), 32'h1);
        for (int k = 0; k < WPL; k++) rd(32'h1000 + 32'(k), 1'b0);
        chk("rdLine_after_l0", 32'(bus.o_rdLine), 32'h1);
        chk("lr_after_drain", 32'(bus.o_lineReady), 32'h0);

        // Both banks full, writer held off
        for (int k = 0; k < 2 * WPL; k++) wr(32'h1000 + 32'(k));
        chk("wrReady_both_full", 32'(bus.o_wrReady), 32'h0);
        bus.i_wrValid = 1'b1;
        bus.i_wrData  = 32'hDEAD_BEEF;
        step();
        bus.i_wrValid = 1'b0;
        chk("wrReady_held", 32'(bus.o_wrReady), 32'h0);
        for (int k = 0; k < WPL; k++) rd(32'h1000 + 32'(k), 1'b0);
        chk("wrReady_reopen", 32'(bus.o_wrReady), 32'h1);
        chk("lr_bank2", 32'(bus.o_lineReady), 32'h1);
        chk("rdLine_2", 32'(bus.o_rdLine), 32'h2);
        for (int k = 0; k < WPL; k++) rd(32'h1028 + 32'(k), 1'b0);
        chk("rdLine_3", 32'(bus.o_rdLine), 32'h3);
        chk("lr_empty", 32'(bus.o_lineReady), 32'h0);

        // Underrun
        rd(32'h0, 1'b0);
        chk("underrun_set", 32'(bus.o_underrun), 32'h1);
        chk("underrun_rdLine", 32'(bus.o_rdLine), 32'h3);
        step();
        chk("underrun_sticky", 32'(bus.o_underrun), 32'h1);
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        chk("flush_underrun", 32'(bus.o_underrun), 32'h0);
        chk("flush_rdLine", 32'(bus.o_rdLine), 32'h0);

        // Flush mid-line with a write offered the same cycle
        for (int k = 0; k < WPL; k++) wr(32'h2000 + 32'(k));
        for (int k = 0; k < 17; k++) rd(32'h2000 + 32'(k), 1'b0);
        bus.i_flush   = 1'b1;
        bus.i_wrValid = 1'b1;
        bus.i_wrData  = 32'hBEEF;
        step();
        bus.i_flush   = 1'b0;
        bus.i_wrValid = 1'b0;
        chk("mflush_wrReady", 32'(bus.o_wrReady), 32'h1);
        chk("mflush_lineReady", 32'(bus.o_lineReady), 32'h0);
        chk("mflush_rdData", bus.o_rdData, 32'h0);
        chk("mflush_rdLine", 32'(bus.o_rdLine), 32'h0);
        for (int k = 0; k < WPL; k++) wr(32'h3000 + 32'(k));
        for (int k = 0; k < WPL; k++) rd(32'h3000 + 32'(k), 1'b0);

        // Asynchronous reset mid-read
        for (int k = 0; k < WPL; k++) wr(32'h4000 + 32'(k));
        for (int k = 0; k < 10; k++) rd(32'h4000 + 32'(k), 1'b0);
        bus.i_rdEnable = 1'b1;
        #2 nreset = 1'b0;
        bus.i_rdEnable = 1'b0;
        #1;
        chk("arst_rdData", bus.o_rdData, 32'h0);
        chk("arst_rdLine", 32'(bus.o_rdLine), 32'h0);
        chk("arst_lineReady", 32'(bus.o_lineReady), 32'h0);
        chk("arst_wrReady", 32'(bus.o_wrReady), 32'h1);
        step();
        nreset = 1'b1;
        step();
        for (int k = 0; k < WPL; k++) wr(32'h5000 + 32'(k));
        for (int k = 0; k < WPL; k++) rd(32'h5000 + 32'(k), 1'b0);
        chk("post_arst_rdLine", 32'(bus.o_rdLine), 32'h1);

        // Full frame, concurrent write and read streaming
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        nw  = 0;
        nr  = 0;
        cyc = 0;
        while ((nw < NW || nr < NW) && cyc < 60000) begin
            bus.i_wrValid  = (nw < NW);
            bus.i_wrData   = 32'hA500_0000 ^ 32'(nw);
            bus.i_rdEnable = bus.o_lineReady && (nr < NW);
            wr_ok = bus.i_wrValid && bus.o_wrReady;
            if (bus.i_rdEnable) begin
                q.push_back('{32'hA500_0000 ^ 32'(nr), (nr == NW - 1)});
                nr++;
            end
            step();
            if (wr_ok) nw++;
            cyc++;
        end
        bus.i_wrValid  = 1'b0;
        bus.i_rdEnable = 1'b0;
        chk("stream_in_budget", 32'(cyc < 60000), 32'h1);
        chk("stream_nr", 32'(nr), 32'(NW));
        step();
        chk("stream_underrun", 32'(bus.o_underrun), 32'h0);
        chk("stream_rdLine_wrap", 32'(bus.o_rdLine), 32'h0);
        chk("stream_lr", 32'(bus.o_lineReady), 32'h0);
        step();
        chk("sb_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
